// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO pointer controllers (write and read side).
package fifo_pkg;

  localparam int FIFO_ADDRSIZE = 4;
  localparam int DEPTH         = 2 ** FIFO_ADDRSIZE;

  // Generic up to 32 bits; unused upper bits must be zero so the prefix XOR is width-agnostic.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < 32; i++) b[i] = ^(g >> i);
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_dec.sv
// Combinational Gray-to-binary decoder (XOR prefix from the MSB down).
module gray2bin_dec #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < W; i++) bin[i] = ^(gray >> i);
  end

endmodule

// File: rtl/wptr_full_prog.sv
// Write-side pointer and flag controller of the dual-clock FIFO (wclk domain only):
// binary/Gray write pointers, RAM address, full, programmable almost-full, level and sticky overflow.
module wptr_full_prog
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE = 4,
  parameter int AFULL_W  = ADDRSIZE + 1
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic [AFULL_W-1:0]  afull_thr,
  input  logic                ovf_clr,
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                wafull,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                wovf
);

  localparam int PW = ADDRSIZE + 1;

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wbnext;
  logic [ADDRSIZE:0] wgnext;
  logic [ADDRSIZE:0] rbin_s;
  logic [ADDRSIZE:0] level_next;
  logic [ADDRSIZE:0] full_cmp;
  logic              wfull_next;
  logic              wafull_next;

  gray2bin_dec #(.W(PW)) u_rptr_dec (
    .gray (wq2_rptr),
    .bin  (rbin_s)
  );

  assign wen   = winc & ~wfull;
  assign waddr = wbin[ADDRSIZE-1:0];

  // Full when the next Gray write pointer matches the read pointer with its two MSBs inverted.
  always_comb begin
    wbnext      = wbin + PW'(wen);
    wgnext      = PW'(bin2gray(32'(wbnext)));
    full_cmp    = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
    wfull_next  = (wgnext == full_cmp);
    level_next  = wbnext - rbin_s;
    wafull_next = (32'(level_next) >= 32'(afull_thr));
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin   <= '0;
      wptr   <= '0;
      wfull  <= 1'b0;
      wafull <= 1'b0;
      wlevel <= '0;
      wovf   <= 1'b0;
    end else begin
      wbin   <= wbnext;
      wptr   <= wgnext;
      wfull  <= wfull_next;
      wafull <= wafull_next;
      wlevel <= level_next;
      // A blocked write re-arms the flag even when a clear arrives in the same cycle.
      wovf   <= (winc & wfull) | (wovf & ~ovf_clr);
    end
  end

endmodule

// File: tb/tb_wptr_full_prog.sv
// Directed self-checking bench for wptr_full_prog at ADDRSIZE=3 (depth 8).
module tb_wptr_full_prog;

  localparam int ADDRSIZE = 3;

  logic                wclk = 1'b0;
  logic                wrst;
  logic                winc;
  logic [ADDRSIZE:0]   wq2_rptr;
  logic [ADDRSIZE:0]   afull_thr;
  logic                ovf_clr;
  logic                wen;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE:0]   wptr;
  logic                wfull;
  logic                wafull;
  logic [ADDRSIZE:0]   wlevel;
  logic                wovf;

  int n_tests = 0;
  int n_fail  = 0;

  wptr_full_prog #(.ADDRSIZE(ADDRSIZE)) dut (
    .wclk      (wclk),
    .wrst      (wrst),
    .winc      (winc),
    .wq2_rptr  (wq2_rptr),
    .afull_thr (afull_thr),
    .ovf_clr   (ovf_clr),
    .wen       (wen),
    .waddr     (waddr),
    .wptr      (wptr),
    .wfull     (wfull),
    .wafull    (wafull),
    .wlevel    (wlevel),
    .wovf      (wovf)
  );

  always #5 wclk = ~wclk;

  // Advance one edge and land 1 time unit after it.
  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    wrst = 1'b1;
    winc = 1'b0;
    ovf_clr = 1'b0;
    step();
    wrst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    wrst = 1'b1; winc = 1'b0; wq2_rptr = '0; afull_thr = 4'd15; ovf_clr = 1'b0;
    step();
    step();
    chk("rst_wptr", wptr, 0);
    chk("rst_wfull", wfull, 0);
    chk("rst_wlevel", wlevel, 0);
    chk("rst_wovf", wovf, 0);
    chk("rst_wafull", wafull, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wen", wen, 0);
    wrst = 1'b0;

    // Fill all 8 entries with no reads.
    for (int i = 0; i < 8; i++) begin
      winc = 1'b1;
      #1;
      chk("fill_wen", wen, 1);
      chk("fill_waddr", waddr, i);
      step();
    end
    winc = 1'b0;
    chk("fill_wfull", wfull, 1);
    chk("fill_wlevel", wlevel, 8);
    chk("fill_wptr", wptr, 4'b1100);
    chk("fill_wafull_thr15", wafull, 0);

    // Writes while full are blocked and flag overflow.
    for (int i = 0; i < 3; i++) begin
      winc = 1'b1;
      #1;
      chk("ovf_wen", wen, 0);
      step();
      chk("ovf_wptr", wptr, 4'b1100);
      chk("ovf_wovf", wovf, 1);
    end
    winc = 1'b0; ovf_clr = 1'b1;
    step();
    chk("ovf_clr", wovf, 0);
    ovf_clr = 1'b0;

    // Reader advances to 2: two slots free, wrap the address back to 0.
    wq2_rptr = 4'b0011;
    step();
    chk("rd2_wfull", wfull, 0);
    chk("rd2_wlevel", wlevel, 6);
    winc = 1'b1;
    #1;
    chk("wrap_waddr0", waddr, 0);
    step();
    chk("wrap_waddr1", waddr, 1);
    step();
    winc = 1'b0;
    chk("wrap_wptr", wptr, 4'b1111);
    chk("wrap_wfull", wfull, 1);
    chk("wrap_wlevel", wlevel, 8);

    // Set and clear together: set wins.
    winc = 1'b1; ovf_clr = 1'b1;
    step();
    chk("setwins_wovf", wovf, 1);
    winc = 1'b0; ovf_clr = 1'b0;

    // Almost-full threshold 6, then retarget to 7.
    wq2_rptr = '0; afull_thr = 4'd6;
    do_reset();
    chk("af_rst_wafull", wafull, 0);
    winc = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("af_lvl5_wafull", wafull, 0);
    chk("af_lvl5_wlevel", wlevel, 5);
    step();
    chk("af_lvl6_wafull", wafull, 1);
    winc = 1'b0; afull_thr = 4'd7;
    step();
    chk("af7_lvl6_wafull", wafull, 0);
    chk("af7_lvl6_wlevel", wlevel, 6);
    winc = 1'b1;
    step();
    chk("af7_lvl7_wafull", wafull, 1);
    step();
    winc = 1'b0;
    chk("af7_lvl8_wafull", wafull, 1);
    chk("af7_lvl8_wfull", wfull, 1);

    // Threshold 0 asserts almost-full from the first edge after reset release.
    afull_thr = 4'd0;
    do_reset();
    chk("af0_rst_wafull", wafull, 0);
    step();
    chk("af0_wafull", wafull, 1);
    afull_thr = 4'd15;

    // Reset in the middle of a burst.
    do_reset();
    winc = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("mid_wlevel5", wlevel, 5);
    wrst = 1'b1;
    step();
    wrst = 1'b0;
    chk("mid_rst_wptr", wptr, 0);
    chk("mid_rst_wlevel", wlevel, 0);
    chk("mid_rst_waddr", waddr, 0);
    chk("mid_rst_wfull", wfull, 0);
    chk("mid_rst_wovf", wovf, 0);
    #1;
    chk("mid_next_wen", wen, 1);
    step();
    winc = 1'b0;
    chk("mid_next_wlevel", wlevel, 1);
    chk("mid_next_waddr", waddr, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
